// File: rtl/game_region_decoder.sv
// -----------------------------------------------------------------------------
// game_region_decoder
//   Compares the VGA raster position against NUM_REGIONS run-time programmable
//   rectangles. CPU writes go to a shadow set. The shadow set is copied to the
//   active set on frame_start, so a region never changes in the middle of a frame.
//   The result appears 2 cycles after the pixel is sampled. It holds per-region
//   hit flags, the lowest-index winning region, and the pixel coordinates
//   relative to the winning region.
//
// Optional feature macro: GAME_REGION_BORDER_EN
//   When defined, on_border[i] flags pixels on the 1-pixel outline of region i.
//   When undefined, on_border is tied to 0 and no border logic is built.
//
// Ports
//   vga_clk      pixel clock (only clock)
//   rst_n        asynchronous active-low reset
//   vga_row/col  current raster position
//   frame_start  one-cycle pulse; copies the shadow set to the active set
//   cfg_we/idx/field/wdata  shadow register write (field 0=row 1=col 2=height 3=width)
//   cfg_pending  an accepted write has not yet been applied by frame_start
//   region_hit   per-region inside flags
//   hit_valid    any region hit
//   hit_idx      lowest-index hit region (0 when none)
//   local_row/col  raster position minus the origin of region hit_idx (0 when none)
//   on_border    per-region outline flags (optional feature)
// -----------------------------------------------------------------------------
module game_region_decoder #(
    parameter int NUM_REGIONS = 8,
    parameter int COORD_W     = 12,
    parameter int IDX_W       = 4
) (
    input  logic                   vga_clk,
    input  logic                   rst_n,
    input  logic [COORD_W-1:0]     vga_row,
    input  logic [COORD_W-1:0]     vga_col,
    input  logic                   frame_start,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [1:0]             cfg_field,
    input  logic [COORD_W-1:0]     cfg_wdata,
    output logic                   cfg_pending,
    output logic [NUM_REGIONS-1:0] region_hit,
    output logic                   hit_valid,
    output logic [IDX_W-1:0]       hit_idx,
    output logic [COORD_W-1:0]     local_row,
    output logic [COORD_W-1:0]     local_col,
    output logic [NUM_REGIONS-1:0] on_border
);

    // One extra bit, so NUM_REGIONS == 2**IDX_W is still representable.
    localparam logic [IDX_W:0]     NUM_REGIONS_W = (IDX_W+1)'(NUM_REGIONS);
    localparam logic [COORD_W-1:0] COORD_ZERO    = {COORD_W{1'b0}};

    logic [COORD_W-1:0] sh_row_r  [NUM_REGIONS];
    logic [COORD_W-1:0] sh_col_r  [NUM_REGIONS];
    logic [COORD_W-1:0] sh_hgt_r  [NUM_REGIONS];
    logic [COORD_W-1:0] sh_wid_r  [NUM_REGIONS];
    logic [COORD_W-1:0] act_row_r [NUM_REGIONS];
    logic [COORD_W-1:0] act_col_r [NUM_REGIONS];
    logic [COORD_W-1:0] act_hgt_r [NUM_REGIONS];
    logic [COORD_W-1:0] act_wid_r [NUM_REGIONS];

    logic                   cfg_accept_s;
    logic [NUM_REGIONS-1:0] hit_s;
    logic [COORD_W-1:0]     roff_s    [NUM_REGIONS];
    logic [COORD_W-1:0]     coff_s    [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] hit_s1_r;
    logic [COORD_W-1:0]     roff_s1_r [NUM_REGIONS];
    logic [COORD_W-1:0]     coff_s1_r [NUM_REGIONS];

    logic                   win_valid_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic [COORD_W-1:0]     win_row_s;
    logic [COORD_W-1:0]     win_col_s;

    // Writes to indices at or beyond NUM_REGIONS are dropped entirely.
    assign cfg_accept_s = cfg_we & ({1'b0, cfg_idx} < NUM_REGIONS_W);

    // Shadow register file: CPU writes land here.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                sh_row_r[i] <= COORD_ZERO;
                sh_col_r[i] <= COORD_ZERO;
                sh_hgt_r[i] <= COORD_ZERO;
                sh_wid_r[i] <= COORD_ZERO;
            end
        end else begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (cfg_accept_s && (cfg_idx == IDX_W'(i))) begin
                    case (cfg_field)
                        2'd0:    sh_row_r[i] <= cfg_wdata;
                        2'd1:    sh_col_r[i] <= cfg_wdata;
                        2'd2:    sh_hgt_r[i] <= cfg_wdata;
                        2'd3:    sh_wid_r[i] <= cfg_wdata;
                        default: sh_row_r[i] <= sh_row_r[i];
                    endcase
                end
            end
        end
    end

    // Active register file: takes the pre-write shadow values on frame_start.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                act_row_r[i] <= COORD_ZERO;
                act_col_r[i] <= COORD_ZERO;
                act_hgt_r[i] <= COORD_ZERO;
                act_wid_r[i] <= COORD_ZERO;
            end
        end else if (frame_start) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                act_row_r[i] <= sh_row_r[i];
                act_col_r[i] <= sh_col_r[i];
                act_hgt_r[i] <= sh_hgt_r[i];
                act_wid_r[i] <= sh_wid_r[i];
            end
        end
    end

    // Pending flag: a write in the same cycle as frame_start overrides the clear.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_pending <= 1'b0;
        end else if (cfg_accept_s) begin
            cfg_pending <= 1'b1;
        end else if (frame_start) begin
            cfg_pending <= 1'b0;
        end
    end

    // Per-region hit test. The end bound is one bit wider, so regions near the
    // top of the coordinate space extend past it instead of wrapping.
    // A zero height or width makes the range empty.
    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        logic [COORD_W:0] row_end_s;
        logic [COORD_W:0] col_end_s;
        assign row_end_s = {1'b0, act_row_r[g]} + {1'b0, act_hgt_r[g]};
        assign col_end_s = {1'b0, act_col_r[g]} + {1'b0, act_wid_r[g]};
        assign hit_s[g]  = (vga_row >= act_row_r[g]) && ({1'b0, vga_row} < row_end_s) &&
                           (vga_col >= act_col_r[g]) && ({1'b0, vga_col} < col_end_s);
        assign roff_s[g] = vga_row - act_row_r[g];
        assign coff_s[g] = vga_col - act_col_r[g];
    end

    // Stage 1: register the hit flags and region-relative offsets.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_s1_r <= {NUM_REGIONS{1'b0}};
            for (int i = 0; i < NUM_REGIONS; i++) begin
                roff_s1_r[i] <= COORD_ZERO;
                coff_s1_r[i] <= COORD_ZERO;
            end
        end else begin
            hit_s1_r <= hit_s;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                roff_s1_r[i] <= roff_s[i];
                coff_s1_r[i] <= coff_s[i];
            end
        end
    end

    // Fixed-priority select. The scan runs from high index to low, so the
    // lowest hitting index is assigned last and wins.
    always_comb begin
        win_valid_s = 1'b0;
        win_idx_s   = {IDX_W{1'b0}};
        win_row_s   = COORD_ZERO;
        win_col_s   = COORD_ZERO;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit_s1_r[i]) begin
                win_valid_s = 1'b1;
                win_idx_s   = IDX_W'(i);
                win_row_s   = roff_s1_r[i];
                win_col_s   = coff_s1_r[i];
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

    // Stage 2: register the outputs, all aligned to the same input pixel.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            region_hit <= {NUM_REGIONS{1'b0}};
            hit_valid  <= 1'b0;
            hit_idx    <= {IDX_W{1'b0}};
            local_row  <= COORD_ZERO;
            local_col  <= COORD_ZERO;
        end else begin
            region_hit <= hit_s1_r;
            hit_valid  <= win_valid_s;
            hit_idx    <= win_idx_s;
            local_row  <= win_row_s;
            local_col  <= win_col_s;
        end
    end

`ifdef GAME_REGION_BORDER_EN
    localparam logic [COORD_W-1:0] COORD_ONE = {{(COORD_W-1){1'b0}}, 1'b1};

    logic [NUM_REGIONS-1:0] bord_s;
    logic [NUM_REGIONS-1:0] bord_s1_r;

    // The outline test uses the same active set as the hit test, so the
    // flags stay consistent if frame_start arrives inside the pipeline.
    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_border
        assign bord_s[g] = hit_s[g] &&
                           ((roff_s[g] == COORD_ZERO) || (roff_s[g] == act_hgt_r[g] - COORD_ONE) ||
                            (coff_s[g] == COORD_ZERO) || (coff_s[g] == act_wid_r[g] - COORD_ONE));
    end

    // Border flags follow the same two-stage pipeline as region_hit.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            bord_s1_r <= {NUM_REGIONS{1'b0}};
            on_border <= {NUM_REGIONS{1'b0}};
        end else begin
            bord_s1_r <= bord_s;
            on_border <= bord_s1_r;
        end
    end
`else
    assign on_border = {NUM_REGIONS{1'b0}};
`endif

endmodule

// File: tb/tb_game_region_decoder.sv
module tb_game_region_decoder;

    localparam int NR = 8;
`ifdef GAME_REGION_BORDER_EN
    localparam bit BORDER_ON = 1'b1;
`else
    localparam bit BORDER_ON = 1'b0;
`endif

    logic        vga_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [11:0] vga_row = 12'd0;
    logic [11:0] vga_col = 12'd0;
    logic        frame_start = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_idx = 4'd0;
    logic [1:0]  cfg_field = 2'd0;
    logic [11:0] cfg_wdata = 12'd0;
    logic        cfg_pending;
    logic [7:0]  region_hit;
    logic        hit_valid;
    logic [3:0]  hit_idx;
    logic [11:0] local_row;
    logic [11:0] local_col;
    logic [7:0]  on_border;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    game_region_decoder #(.NUM_REGIONS(NR), .COORD_W(12), .IDX_W(4)) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .vga_row(vga_row), .vga_col(vga_col),
        .frame_start(frame_start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .cfg_pending(cfg_pending),
        .region_hit(region_hit), .hit_valid(hit_valid), .hit_idx(hit_idx),
        .local_row(local_row), .local_col(local_col), .on_border(on_border)
    );

    always #5 vga_clk = ~vga_clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [7:0]  hit;
        logic        valid;
        logic [3:0]  idx;
        logic [11:0] lr;
        logic [11:0] lc;
        logic [7:0]  bord;
    } exp_t;

    // Rectangle table: [region][0=row 1=col 2=height 3=width]
    int   m_sh  [NR][4];
    int   m_act [NR][4];
    bit   m_pend;
    exp_t m_d1, m_now;

    function automatic exp_t model_px(input int r, input int c);
        exp_t e;
        int row, col, h, w;
        e = '0;
        for (int i = 0; i < NR; i++) begin
            row = m_act[i][0]; col = m_act[i][1]; h = m_act[i][2]; w = m_act[i][3];
            if (r >= row && r < row + h && c >= col && c < col + w) begin
                e.hit[i] = 1'b1;
                if (BORDER_ON && (r == row || r == row + h - 1 || c == col || c == col + w - 1))
                    e.bord[i] = 1'b1;
                if (!e.valid) begin
                    e.valid = 1'b1;
                    e.idx   = 4'(i);
                    e.lr    = 12'(r - row);
                    e.lc    = 12'(c - col);
                end
            end
        end
        return e;
    endfunction

    always @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++)
                for (int k = 0; k < 4; k++) begin
                    m_sh[i][k]  <= 0;
                    m_act[i][k] <= 0;
                end
            m_pend <= 1'b0;
            m_d1   <= '0;
            m_now  <= '0;
        end else begin
            m_now <= m_d1;
            m_d1  <= model_px(int'(vga_row), int'(vga_col));
            if (frame_start)
                for (int i = 0; i < NR; i++)
                    for (int k = 0; k < 4; k++)
                        m_act[i][k] <= m_sh[i][k];
            if (cfg_we && int'(cfg_idx) < NR) begin
                m_sh[cfg_idx][cfg_field] <= int'(cfg_wdata);
                m_pend <= 1'b1;
            end else if (frame_start) begin
                m_pend <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge vga_clk) begin
        if (check_en) begin
            checks++;
            if (region_hit !== m_now.hit || hit_valid !== m_now.valid || hit_idx !== m_now.idx ||
                local_row !== m_now.lr || local_col !== m_now.lc || on_border !== m_now.bord ||
                cfg_pending !== m_pend) begin
                failures++;
                $display("FAIL model_cmp t=%0t actual hit=%h v=%b idx=%0d lr=%0d lc=%0d b=%h p=%b expected hit=%h v=%b idx=%0d lr=%0d lc=%0d b=%h p=%b",
                         $time, region_hit, hit_valid, hit_idx, local_row, local_col, on_border, cfg_pending,
                         m_now.hit, m_now.valid, m_now.idx, m_now.lr, m_now.lc, m_now.bord, m_pend);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input int r, input int c, input logic fs, input logic we,
                         input int idx, input int fld, input int data);
        @(negedge vga_clk);
        vga_row     = 12'(r);
        vga_col     = 12'(c);
        frame_start = fs;
        cfg_we      = we;
        cfg_idx     = 4'(idx);
        cfg_field   = 2'(fld);
        cfg_wdata   = 12'(data);
    endtask

    task automatic idle();
        drive(0, 0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic cfg_write(input int idx, input int fld, input int data);
        drive(0, 0, 1'b0, 1'b1, idx, fld, data);
        idle();
    endtask

    task automatic set_region(input int idx, input int r, input int c, input int h, input int w);
        cfg_write(idx, 0, r);
        cfg_write(idx, 1, c);
        cfg_write(idx, 2, h);
        cfg_write(idx, 3, w);
    endtask

    task automatic fs_pulse();
        drive(0, 0, 1'b1, 1'b0, 0, 0, 0);
        idle();
    endtask

    task automatic probe(input string name, input int r, input int c, input logic [7:0] eh,
                         input logic ev, input int ei, input int elr, input int elc);
        drive(r, c, 1'b0, 1'b0, 0, 0, 0);
        repeat (2) @(negedge vga_clk);
        chk({name, "_hit"},   32'(region_hit), 32'(eh));
        chk({name, "_valid"}, 32'(hit_valid),  32'(ev));
        chk({name, "_idx"},   32'(hit_idx),    32'(ei));
        chk({name, "_lrow"},  32'(local_row),  32'(elr));
        chk({name, "_lcol"},  32'(local_col),  32'(elc));
    endtask

    task automatic probe_border(input string name, input int r, input int c, input logic exp_b);
        probe(name, r, c, 8'h01, 1'b1, 0, r, c);
        chk({name, "_border"}, 32'(on_border), {31'd0, exp_b & BORDER_ON});
    endtask

    // ---------------- directed tests ----------------
    bit seen;

    initial begin
        repeat (3) @(negedge vga_clk);
        chk("rst_hit",     32'(region_hit),  32'd0);
        chk("rst_pending", 32'(cfg_pending), 32'd0);
        rst_n = 1'b1;
        check_en = 1'b1;

        // 1: no configuration, subsampled raster sweep
        fs_pulse();
        seen = 1'b0;
        for (int r = 0; r < 480; r += 32)
            for (int c = 0; c < 640; c += 16) begin
                drive(r, c, 1'b0, 1'b0, 0, 0, 0);
                if (region_hit != 8'd0 || hit_valid || cfg_pending || local_row != 12'd0) seen = 1'b1;
            end
        chk("sweep_all_zero", 32'(seen), 32'd0);

        // 2: single large region
        set_region(0, 40, 200, 400, 240);
        chk("pend_after_write", 32'(cfg_pending), 32'd1);
        fs_pulse();
        chk("pend_after_fs", 32'(cfg_pending), 32'd0);
        probe("r0_origin", 40, 200, 8'h01, 1'b1, 0, 0, 0);
        probe("r0_corner", 439, 439, 8'h01, 1'b1, 0, 399, 239);
        probe("r0_below", 440, 200, 8'h00, 1'b0, 0, 0, 0);
        probe("r0_right", 40, 440, 8'h00, 1'b0, 0, 0, 0);

        // 3: overlap, lowest index wins
        set_region(3, 100, 250, 20, 20);
        fs_pulse();
        probe("overlap", 105, 255, 8'h09, 1'b1, 0, 65, 55);
        probe("r3_only_miss", 125, 255, 8'h01, 1'b1, 0, 85, 55);

        // 4: shadow/active timing
        set_region(1, 300, 0, 10, 10);
        fs_pulse();
        cfg_write(1, 0, 10);
        chk("pend_mid_frame", 32'(cfg_pending), 32'd1);
        probe("r1_not_yet", 12, 5, 8'h00, 1'b0, 0, 0, 0);
        fs_pulse();
        chk("pend_cleared", 32'(cfg_pending), 32'd0);
        probe("r1_applied", 12, 5, 8'h02, 1'b1, 1, 2, 5);
        drive(0, 0, 1'b1, 1'b1, 1, 0, 20);
        idle();
        chk("pend_coincident", 32'(cfg_pending), 32'd1);
        probe("r1_old_kept", 12, 5, 8'h02, 1'b1, 1, 2, 5);
        probe("r1_new_not_yet", 22, 5, 8'h00, 1'b0, 0, 0, 0);
        fs_pulse();
        chk("pend_cleared2", 32'(cfg_pending), 32'd0);
        probe("r1_new_applied", 22, 5, 8'h02, 1'b1, 1, 2, 5);
        probe("r1_old_gone", 12, 5, 8'h00, 1'b0, 0, 0, 0);

        // 5: no wrap at the top of the coordinate space; out-of-range index
        set_region(2, 4090, 4090, 10, 10);
        fs_pulse();
        probe("r2_top", 4095, 4095, 8'h04, 1'b1, 2, 5, 5);
        probe("r2_no_wrap", 2, 2, 8'h00, 1'b0, 0, 0, 0);
        cfg_write(15, 2, 5);
        chk("pend_bad_idx", 32'(cfg_pending), 32'd0);
        cfg_write(8, 0, 5);
        chk("pend_idx8", 32'(cfg_pending), 32'd0);

        // 6: asynchronous reset mid-frame, then border
        cfg_write(5, 0, 7);
        drive(4095, 4095, 1'b0, 1'b0, 0, 0, 0);
        repeat (2) @(negedge vga_clk);
        chk("pre_rst_valid", 32'(hit_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_hit",   32'(region_hit),  32'd0);
        chk("async_rst_valid", 32'(hit_valid),   32'd0);
        chk("async_rst_lrow",  32'(local_row),   32'd0);
        chk("async_rst_pend",  32'(cfg_pending), 32'd0);
        @(negedge vga_clk);
        rst_n = 1'b1;
        fs_pulse();
        probe("post_rst_miss", 4095, 4095, 8'h00, 1'b0, 0, 0, 0);
        set_region(0, 0, 0, 4, 4);
        fs_pulse();
        probe_border("b_0_2", 0, 2, 1'b1);
        probe_border("b_3_1", 3, 1, 1'b1);
        probe_border("b_1_1", 1, 1, 1'b0);
        probe_border("b_2_2", 2, 2, 1'b0);
        idle();

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
